ctrl_decode_pipe: RTL and testbench
===================================

Name: ctrl_decode_pipe

Overview:
Parametrised successor to the single-cycle ID control decoder. It decodes the IF/ID instruction into an extended control bundle and performs load-use hazard detection with bubble insertion. It owns the ID/EX control pipeline register, which it can hold, flush or load. It also flags illegal opcodes and counts them.
Sits between the IF/ID register and EX; drives stall_if back to the PC and IF/ID enables.

Parameters:
EXT_EN, 1, 1 = also decode LUI/AUIPC/JAL/JALR; 0 = base set only (R-type, LW, SW, BEQ, ADDI), others illegal
REG_AW, 5, register-address width
CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
instr_valid  in  1  IF/ID holds a real instruction
instr  in  32  IF/ID instruction word
flush  in  1  branch/jump taken in EX; kill ID/EX contents
ex_hold  in  1  downstream stall; freeze ID/EX
stall_if  out  1  hold PC and IF/ID this cycle (combinational)
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_ctrl  out  ctrl_v2_t  registered control bundle
id_ex_rd  out  REG_AW  registered destination register
id_ex_rs1  out  REG_AW  registered source 1
id_ex_rs2  out  REG_AW  registered source 2
illegal  out  1  registered; 1 for one cycle after an illegal instruction enters ID/EX
illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (rst=1 at a clock edge): id_ex_valid=0, id_ex_ctrl all-zero, id_ex_rd/rs1/rs2=0, illegal=0, illegal_cnt=0. stall_if=0 while ID/EX is invalid.
- Decode is combinational, with no latching. Every field of the bundle has a defined value for every opcode; unused fields are 0 and no field is ever x.
- Base encodings are unchanged: R-type ALU_Op=10, Src=0, reg_write=1. LW ALU_Op=00, Src=1, mem_read=1, reg_write=1, mem_to_reg=1. SW ALU_Op=00, Src=1, mem_write=1. BEQ ALU_Op=01, branch=1. ADDI ALU_Op=00, Src=1, reg_write=1.
- EXT_EN=1 adds the following encodings:
  - LUI: lui=1, Src=1, reg_write=1.
  - AUIPC: pc_src_a=1, Src=1, reg_write=1.
  - JAL: jump=1, link=1, reg_write=1.
  - JALR: jump=1, jalr=1, link=1, Src=1, reg_write=1.
- Illegal opcode: the bundle is all-zero and ill=1.
- uses_rs1 is 1 for R, LW, SW, BEQ, ADDI and JALR. uses_rs2 is 1 for R, SW and BEQ.
- Hazard (hz): instr_valid & id_ex_valid & id_ex_ctrl.mem_read & (id_ex_rd≠0) & ((uses_rs1 & rs1==id_ex_rd) | (uses_rs2 & rs2==id_ex_rd)).
- stall_if = ~flush & (ex_hold | hz).
- ID/EX update priority per edge: rst > flush > ex_hold > hz > load.
  - flush: valid=0, ctrl zeroed; current ID instruction is dropped by the fetch-side flush.
  - ex_hold: all ID/EX outputs keep their values.
  - hz: insert bubble (valid=0, ctrl zero, rd=0); ID instruction held.
  - load: valid=instr_valid, ctrl=decoded bundle (zeroed if ~instr_valid), rd/rs1/rs2 = instr[11:7]/[19:15]/[24:20].
- A load-use stall lasts exactly 1 cycle: after the bubble, id_ex_valid=0, so hz clears.
- illegal=1 only on a load edge with instr_valid and ill. illegal_cnt increments on that same edge and saturates at 2^CNT_W−1.
- Instructions with rd=x0 never cause a hazard.
- flush and ex_hold together: flush wins.

Decomposition:
- Shared package ctrl_pkg:
  - ctrl_v2_t struct: existing EX/M/WB fields plus jump, jalr, link, lui, pc_src_a.
  - Opcode localparams: LW, SW, R_TYPE, BEQ, ADDI, LUI, AUIPC, JAL, JALR.
  - CTRL_NOP constant (all-zero bundle).
- One sub-module ctrl_decoder: combinational, parameter EXT_EN, inputs instr, outputs ctrl_v2_t, ill, uses_rs1, uses_rs2.
- ctrl_decode_pipe contains the hazard logic, the ID/EX register and the counter.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with instr_valid=1 → next cycle id_ex_valid=1, ALU_Op=00, Src=1, reg_write=1, rd=1, stall_if=0.
- LW x5,0(x1) (0x0000A283) followed by ADD x6,x5,x2 (0x00228333) → stall_if=1 for exactly 1 cycle, then a bubble (id_ex_valid=0). ADD enters ID/EX the next cycle with rs1=5.
- LW x0,0(x1) followed by an instruction reading x0 → no stall.
- EXT_EN=0, JAL x1,0 (0x000000EF) → ctrl all-zero, illegal=1 for 1 cycle, illegal_cnt=1. With EXT_EN=1 the same word → jump=1, link=1, reg_write=1, illegal=0.
- ex_hold=1 for 3 cycles while ID/EX holds SW → outputs unchanged and stall_if=1 throughout. Asserting flush in cycle 2 → id_ex_valid=0 on the next edge and stall_if=0.
- CNT_W=2, 5 illegal words 0x0000007F → illegal_cnt sequence 1, 2, 3, 3, 3. rst mid-sequence → all outputs 0 on the next edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-bundle type, opcode constants and NOP bundle
package ctrl_pkg;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       jump;
      logic       jalr;
      logic       link;
      logic       lui;
      logic       pc_src_a;
   } ctrl_v2_t;

   localparam logic [6:0] LW     = 7'b0000011;
   localparam logic [6:0] SW     = 7'b0100011;
   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] BEQ    = 7'b1100011;
   localparam logic [6:0] ADDI   = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   localparam ctrl_v2_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational opcode decode into the extended control bundle
module ctrl_decoder
   import ctrl_pkg::*;
#(
   parameter bit EXT_EN = 1'b1
) (
   input  logic [31:0] instr,
   output ctrl_v2_t    ctrl,
   output logic        ill,
   output logic        uses_rs1,
   output logic        uses_rs2
);

   logic [6:0] opcode;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign unused_bits = ^instr[31:7];

   always_comb begin
      ctrl     = CTRL_NOP;
      ill      = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode)
         R_TYPE: begin
            ctrl.alu_op    = 2'b10;
            ctrl.reg_write = 1'b1;
            uses_rs1       = 1'b1;
            uses_rs2       = 1'b1;
         end
         LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            uses_rs1        = 1'b1;
         end
         SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            uses_rs1       = 1'b1;
            uses_rs2       = 1'b1;
         end
         BEQ: begin
            ctrl.alu_op = 2'b01;
            ctrl.branch = 1'b1;
            uses_rs1    = 1'b1;
            uses_rs2    = 1'b1;
         end
         ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            uses_rs1       = 1'b1;
         end
         LUI: begin
            if (EXT_EN) begin
               ctrl.lui       = 1'b1;
               ctrl.alu_src   = 1'b1;
               ctrl.reg_write = 1'b1;
            end else begin
               ill = 1'b1;
            end
         end
         AUIPC: begin
            if (EXT_EN) begin
               ctrl.pc_src_a  = 1'b1;
               ctrl.alu_src   = 1'b1;
               ctrl.reg_write = 1'b1;
            end else begin
               ill = 1'b1;
            end
         end
         JAL: begin
            if (EXT_EN) begin
               ctrl.jump      = 1'b1;
               ctrl.link      = 1'b1;
               ctrl.reg_write = 1'b1;
            end else begin
               ill = 1'b1;
            end
         end
         JALR: begin
            if (EXT_EN) begin
               ctrl.jump      = 1'b1;
               ctrl.jalr      = 1'b1;
               ctrl.link      = 1'b1;
               ctrl.alu_src   = 1'b1;
               ctrl.reg_write = 1'b1;
               uses_rs1       = 1'b1;
            end else begin
               ill = 1'b1;
            end
         end
         default: ill = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - ID decode, load-use hazard bubble, ID/EX control register
// and saturating illegal-instruction counter.
module ctrl_decode_pipe
   import ctrl_pkg::*;
#(
   parameter bit EXT_EN = 1'b1,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [31:0]       instr,
   input  logic              flush,
   input  logic              ex_hold,
   output logic              stall_if,
   output logic              id_ex_valid,
   output ctrl_v2_t          id_ex_ctrl,
   output logic [REG_AW-1:0] id_ex_rd,
   output logic [REG_AW-1:0] id_ex_rs1,
   output logic [REG_AW-1:0] id_ex_rs2,
   output logic              illegal,
   output logic [CNT_W-1:0]  illegal_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ctrl_v2_t          dec_ctrl;
   logic              dec_ill;
   logic              uses_rs1;
   logic              uses_rs2;
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic              hz;
   logic              take_ill;

   ctrl_decoder #(
      .EXT_EN (EXT_EN)
   ) u_dec (
      .instr    (instr),
      .ctrl     (dec_ctrl),
      .ill      (dec_ill),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2)
   );

   assign rd  = REG_AW'(instr[11:7]);
   assign rs1 = REG_AW'(instr[19:15]);
   assign rs2 = REG_AW'(instr[24:20]);

   // A load in EX whose result the ID instruction reads needs one bubble.
   assign hz = instr_valid & id_ex_valid & id_ex_ctrl.mem_read & (id_ex_rd != '0)
             & ((uses_rs1 & (rs1 == id_ex_rd)) | (uses_rs2 & (rs2 == id_ex_rd)));

   assign stall_if = ~flush & (ex_hold | hz);
   assign take_ill = instr_valid & dec_ill;

   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_valid <= 1'b0;
         id_ex_ctrl  <= CTRL_NOP;
         id_ex_rd    <= '0;
         id_ex_rs1   <= '0;
         id_ex_rs2   <= '0;
         illegal     <= 1'b0;
         illegal_cnt <= '0;
      end else if (flush) begin
         id_ex_valid <= 1'b0;
         id_ex_ctrl  <= CTRL_NOP;
         illegal     <= 1'b0;
      end else if (ex_hold) begin
         illegal     <= 1'b0;
      end else if (hz) begin
         id_ex_valid <= 1'b0;
         id_ex_ctrl  <= CTRL_NOP;
         id_ex_rd    <= '0;
         illegal     <= 1'b0;
      end else begin
         id_ex_valid <= instr_valid;
         id_ex_ctrl  <= instr_valid ? dec_ctrl : CTRL_NOP;
         id_ex_rd    <= rd;
         id_ex_rs1   <= rs1;
         id_ex_rs2   <= rs2;
         illegal     <= take_ill;
         if (take_ill && (illegal_cnt != CNT_MAX))
            illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - scoreboard bench for ctrl_decode_pipe, EXT_EN=1/CNT_W=8
// and EXT_EN=0/CNT_W=2 instances sharing one stimulus stream.
module tb_ctrl_decode_pipe;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        flush = 1'b0;
   logic        ex_hold = 1'b0;

   logic       stall_e, valid_e, ill_e, stall_b, valid_b, ill_b;
   ctrl_v2_t   ctrl_e, ctrl_b;
   logic [4:0] rd_e, rs1_e, rs2_e, rd_b, rs1_b, rs2_b;
   logic [7:0] cnt_e;
   logic [1:0] cnt_b;

   typedef struct {
      bit         stall;
      bit         v;
      ctrl_v2_t   c;
      logic [4:0] rd, rs1, rs2;
      bit         il;
      int         cnt;
   } exp_t;

   exp_t q_e[$];
   exp_t q_b[$];
   exp_t m[2];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ctrl_decode_pipe #(.EXT_EN(1'b1), .REG_AW(5), .CNT_W(8)) dut_e (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .flush(flush),
      .ex_hold(ex_hold), .stall_if(stall_e), .id_ex_valid(valid_e), .id_ex_ctrl(ctrl_e),
      .id_ex_rd(rd_e), .id_ex_rs1(rs1_e), .id_ex_rs2(rs2_e), .illegal(ill_e),
      .illegal_cnt(cnt_e));

   ctrl_decode_pipe #(.EXT_EN(1'b0), .REG_AW(5), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .flush(flush),
      .ex_hold(ex_hold), .stall_if(stall_b), .id_ex_valid(valid_b), .id_ex_ctrl(ctrl_b),
      .id_ex_rd(rd_b), .id_ex_rs1(rs1_b), .id_ex_rs2(rs2_b), .illegal(ill_b),
      .illegal_cnt(cnt_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference decode straight from the instruction-set table.
   function automatic void ref_decode(input logic [31:0] w, input bit ext, output ctrl_v2_t c,
                                      output bit ill, output bit u1, output bit u2);
      c = '0; ill = 0; u1 = 0; u2 = 0;
      case (w[6:0])
         7'h33: begin c.alu_op = 2'b10; c.reg_write = 1; u1 = 1; u2 = 1; end
         7'h03: begin c.alu_src = 1; c.mem_read = 1; c.reg_write = 1; c.mem_to_reg = 1; u1 = 1; end
         7'h23: begin c.alu_src = 1; c.mem_write = 1; u1 = 1; u2 = 1; end
         7'h63: begin c.alu_op = 2'b01; c.branch = 1; u1 = 1; u2 = 1; end
         7'h13: begin c.alu_src = 1; c.reg_write = 1; u1 = 1; end
         7'h37: begin c.lui = 1; c.alu_src = 1; c.reg_write = 1; ill = !ext; end
         7'h17: begin c.pc_src_a = 1; c.alu_src = 1; c.reg_write = 1; ill = !ext; end
         7'h6F: begin c.jump = 1; c.link = 1; c.reg_write = 1; ill = !ext; end
         7'h67: begin c.jump = 1; c.jalr = 1; c.link = 1; c.alu_src = 1; c.reg_write = 1;
                      u1 = 1; ill = !ext; end
         default: ill = 1;
      endcase
      if (ill) begin c = '0; u1 = 0; u2 = 0; end
   endfunction

   task automatic step(input bit r, input bit iv, input logic [31:0] w, input bit fl, input bit hd);
      @(negedge clk);
      rst = r; instr_valid = iv; instr = w; flush = fl; ex_hold = hd;
      for (int k = 0; k < 2; k++) begin
         exp_t     e;
         ctrl_v2_t dc;
         bit       ill, u1, u2, hz;
         int       cmax;
         cmax = (k == 0) ? 255 : 3;
         ref_decode(w, k == 0, dc, ill, u1, u2);
         hz = iv && m[k].v && m[k].c.mem_read && (m[k].rd != 0)
              && ((u1 && w[19:15] == m[k].rd) || (u2 && w[24:20] == m[k].rd));
         e = m[k];
         e.stall = !fl && (hd || hz);
         if (r) begin
            e.v = 0; e.c = '0; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.il = 0; e.cnt = 0;
         end else if (fl) begin
            e.v = 0; e.c = '0; e.il = 0;
         end else if (hd) begin
            e.il = 0;
         end else if (hz) begin
            e.v = 0; e.c = '0; e.rd = 0; e.il = 0;
         end else begin
            e.v = iv; e.c = iv ? dc : '0;
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            e.il = iv && ill;
            if (iv && ill && e.cnt < cmax) e.cnt++;
         end
         m[k] = e;
         if (k == 0) q_e.push_back(e); else q_b.push_back(e);
      end
   endtask

   // Monitor: stall_if before the edge, registered outputs just after it.
   initial begin
      exp_t ee, eb;
      forever begin
         @(negedge clk);
         #3;
         if (q_e.size() > 0 && q_b.size() > 0) begin
            ee = q_e[0];
            eb = q_b[0];
            chk("stall_e", stall_e, ee.stall);
            chk("stall_b", stall_b, eb.stall);
            @(posedge clk);
            #1;
            ee = q_e.pop_front();
            eb = q_b.pop_front();
            chk("valid_e", valid_e, ee.v);
            chk("ctrl_e", ctrl_e, ee.c);
            chk("rd_e", rd_e, ee.rd);
            chk("rs1_e", rs1_e, ee.rs1);
            chk("rs2_e", rs2_e, ee.rs2);
            chk("illegal_e", ill_e, ee.il);
            chk("cnt_e", cnt_e, ee.cnt);
            chk("valid_b", valid_b, eb.v);
            chk("ctrl_b", ctrl_b, eb.c);
            chk("rd_b", rd_b, eb.rd);
            chk("rs1_b", rs1_b, eb.rs1);
            chk("rs2_b", rs2_b, eb.rs2);
            chk("illegal_b", ill_b, eb.il);
            chk("cnt_b", cnt_b, eb.cnt);
         end
      end
   end

   initial begin
      logic [6:0]  ops [10];
      logic [31:0] w;
      ops = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
      for (int k = 0; k < 2; k++) begin
         m[k].stall = 0; m[k].v = 0; m[k].c = '0; m[k].rd = 0; m[k].rs1 = 0;
         m[k].rs2 = 0; m[k].il = 0; m[k].cnt = 0;
      end
      repeat (2) @(posedge clk);

      step(1, 0, 32'h0, 0, 0);
      step(0, 1, 32'h00500093, 0, 0);   // ADDI x1,x0,5
      step(0, 1, 32'h0000A283, 0, 0);   // LW x5,0(x1)
      step(0, 1, 32'h00228333, 0, 0);   // ADD x6,x5,x2 -> bubble
      step(0, 1, 32'h00228333, 0, 0);   // ADD enters ID/EX
      step(0, 1, 32'h0000A003, 0, 0);   // LW x0,0(x1)
      step(0, 1, 32'h00000333, 0, 0);   // ADD x6,x0,x0 -> no stall
      step(0, 1, 32'h000000EF, 0, 0);   // JAL x1,0
      step(0, 0, 32'h0, 0, 0);
      step(0, 1, 32'h0020A023, 0, 0);   // SW x2,0(x1)
      step(0, 1, 32'h00500093, 0, 1);
      step(0, 1, 32'h00500093, 1, 1);   // flush wins over hold
      step(0, 1, 32'h00500093, 0, 1);
      step(1, 0, 32'h0, 0, 0);
      repeat (3) step(0, 1, 32'h0000007F, 0, 0);
      step(1, 1, 32'h0000007F, 0, 0);
      repeat (5) step(0, 1, 32'h0000007F, 0, 0);

      for (int i = 0; i < 2000; i++) begin
         w = $urandom;
         w[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
         w[11:7]  = 5'($urandom_range(0, 3));
         w[19:15] = 5'($urandom_range(0, 3));
         w[24:20] = 5'($urandom_range(0, 3));
         step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, w,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      end
      step(0, 0, 32'h0, 0, 0);

      for (int i = 0; i < 10 && q_e.size() > 0; i++) @(posedge clk);
      #5;
      checks++;
      if (q_e.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q_e.size() + q_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
